// File: rtl/fnd_pkg.sv
`default_nettype none
// fnd_pkg: segment glyphs, digit record and divider helper for the FND scan driver.
// Revision 1.0
package fnd_pkg;

  // Active-low segment glyphs, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int DP_BIT = 7;

  typedef struct packed {
    logic [3:0] value;
    logic       dash;
    logic       dp;
  } digit_t;

  function automatic int fnd_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_seg_decoder.sv
`default_nettype none
// fnd_seg_decoder: decimal digit to active-low seven-segment font, with dash and dp overrides.
// Revision 1.0
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  input  logic       dp,
  output logic [7:0] font
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    if (dash) begin
      glyph = SEG_DASH;
    end
    font = glyph;
    if (dp) begin
      font[DP_BIT] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_display.sv
`default_nettype none
// fnd_scan_display: 4-digit multiplexed common-anode FND driver for stopwatch/clock fields.
// Revision 1.0
module fnd_scan_display
  import fnd_pkg::*;
#(
  parameter int BIT_100HZ = 100,
  parameter int SECOND_60 = 60,
  parameter int HOUR      = 24,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_mode,
  input  logic [$clog2(BIT_100HZ)-1:0] msec,
  input  logic [$clog2(SECOND_60)-1:0] sec,
  input  logic [$clog2(SECOND_60)-1:0] min,
  input  logic [$clog2(HOUR)-1:0]      hour,
  output logic [3:0]                   fnd_com,
  output logic [7:0]                   fnd_font
);

  localparam int DIV   = fnd_div(CLK_HZ, SCAN_HZ);
  localparam int CNT_W = $clog2(DIV);
  localparam int MS_W  = $clog2(BIT_100HZ);
  localparam int SM_W  = $clog2(SECOND_60);
  localparam int HR_W  = $clog2(HOUR);

  logic [CNT_W-1:0] scan_cnt;
  logic             tick;
  logic [1:0]       idx;
  logic             running;

  logic             snap_mode;
  logic [MS_W-1:0]  snap_msec;
  logic [SM_W-1:0]  snap_sec;
  logic [SM_W-1:0]  snap_min;
  logic [HR_W-1:0]  snap_hour;

  int               hi_val;
  int               lo_val;
  logic             hi_bad;
  logic             lo_bad;
  logic             dp_on;
  digit_t           cur;
  logic [7:0]       font;

  assign tick = (scan_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // idx resets to 3 so the first tick both selects digit 0 and takes a snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 2'd3;
      running   <= 1'b0;
      snap_mode <= 1'b0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (tick) begin
      idx     <= idx + 2'd1;
      running <= 1'b1;
      if (idx == 2'd3) begin
        snap_mode <= disp_mode;
        snap_msec <= msec;
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
      end
    end
  end

  always_comb begin
    hi_val = snap_mode ? int'(snap_hour) : int'(snap_sec);
    lo_val = snap_mode ? int'(snap_min)  : int'(snap_msec);
    hi_bad = snap_mode ? (hi_val >= HOUR)      : (hi_val >= SECOND_60);
    lo_bad = snap_mode ? (lo_val >= SECOND_60) : (lo_val >= BIT_100HZ);
    dp_on  = int'(snap_msec) < (BIT_100HZ / 2);
  end

  always_comb begin
    cur = '0;
    case (idx)
      2'd0: begin
        cur.value = 4'(lo_val % 10);
        cur.dash  = lo_bad;
      end
      2'd1: begin
        cur.value = 4'(lo_val / 10);
        cur.dash  = lo_bad;
      end
      2'd2: begin
        cur.value = 4'(hi_val % 10);
        cur.dash  = hi_bad;
        cur.dp    = dp_on;
      end
      default: begin
        cur.value = 4'(hi_val / 10);
        cur.dash  = hi_bad;
      end
    endcase
  end

  fnd_seg_decoder u_seg_decoder (
    .digit (cur.value),
    .dash  (cur.dash),
    .dp    (cur.dp),
    .font  (font)
  );

  // Outputs stay dark until the first tick has produced a real snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= 4'b1111;
      fnd_font <= SEG_BLANK;
    end else if (running) begin
      fnd_com  <= ~(4'b0001 << idx);
      fnd_font <= font;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_display.sv
`default_nettype none
// tb_fnd_scan_display: scoreboard bench for the FND scan driver (DIV = 10).
// Revision 1.0
module tb_fnd_scan_display;

  localparam int DIV = 10;

  typedef struct {
    bit mode;
    int ms;
    int s;
    int m;
    int h;
  } stim_t;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_mode = 1'b0;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;

  fnd_scan_display #(
    .BIT_100HZ (100),
    .SECOND_60 (60),
    .HOUR      (24),
    .CLK_HZ    (1000),
    .SCAN_HZ   (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_mode (disp_mode),
    .msec      (msec),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .fnd_com   (fnd_com),
    .fnd_font  (fnd_font)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  bit         mon_en = 1'b0;
  logic [3:0] prev_com = 4'hF;
  logic [7:0] prev_font = 8'hFF;
  int         hold = 0;
  bit         font_moved = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic stim_t mk(input bit mode, input int ms, input int s, input int m, input int h);
    stim_t t;
    t.mode = mode; t.ms = ms; t.s = s; t.m = m; t.h = h;
    return t;
  endfunction

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_font(input stim_t t, input int pos);
    int         hi;
    int         lo;
    bit         hi_bad;
    bit         lo_bad;
    logic [7:0] f;
    hi     = t.mode ? t.h : t.s;
    lo     = t.mode ? t.m : t.ms;
    hi_bad = t.mode ? (t.h >= 24) : (t.s >= 60);
    lo_bad = t.mode ? (t.m >= 60) : (t.ms >= 100);
    case (pos)
      0:       f = lo_bad ? 8'hBF : seg(lo % 10);
      1:       f = lo_bad ? 8'hBF : seg(lo / 10);
      2:       f = hi_bad ? 8'hBF : seg(hi % 10);
      default: f = hi_bad ? 8'hBF : seg(hi / 10);
    endcase
    if (pos == 2 && t.ms < 50) f[7] = 1'b0;
    return f;
  endfunction

  // Apply a frame's inputs and queue the four digits it must produce.
  task automatic drive(input stim_t t);
    exp_t e;
    disp_mode = t.mode;
    msec      = 7'(t.ms);
    sec       = 6'(t.s);
    min       = 6'(t.m);
    hour      = 5'(t.h);
    for (int p = 0; p < 4; p++) begin
      e.com  = 4'b1111 ^ (4'b0001 << p);
      e.font = exp_font(t, p);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (fnd_com !== prev_com) begin
          if (prev_com !== 4'hF) check("hold_cycles", hold, DIV);
          if (prev_com !== 4'hF) check("font_stable", font_moved, 0);
          check("onehot", $countones(~fnd_com), 1);
          check("sb_has_entry", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("com", fnd_com, e.com);
            check("font", fnd_font, e.font);
          end
          prev_com   = fnd_com;
          prev_font  = fnd_font;
          hold       = 1;
          font_moved = 1'b0;
        end else begin
          if (fnd_font !== prev_font) font_moved = 1'b1;
          hold++;
        end
      end
    end
  end

  stim_t tbl[9];

  initial begin : main
    int n;
    tbl[0] = mk(0, 34, 12, 0, 0);
    tbl[1] = mk(0, 67, 12, 0, 0);
    tbl[2] = mk(1, 67, 12, 5, 23);
    tbl[3] = mk(1, 10, 12, 5, 23);
    tbl[4] = mk(0, 5, 60, 5, 23);
    tbl[5] = mk(1, 50, 59, 59, 24);
    tbl[6] = mk(1, 49, 0, 60, 9);
    tbl[7] = mk(0, 100, 59, 0, 0);
    tbl[8] = mk(0, 49, 45, 0, 0);

    drive(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_com", fnd_com, 4'hF);
    check("reset_font", fnd_font, 8'hFF);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    wait_cyc(10);
    check("pre_scan_com", fnd_com, 4'hF);
    check("pre_scan_font", fnd_font, 8'hFF);
    wait_cyc(11);
    check("first_digit_com", fnd_com, 4'b1110);

    // Next frame's inputs land while idx = 1 of the current frame.
    for (int k = 1; k < 9; k++) begin
      wait_cyc(10 + 40 * k - 25);
      drive(tbl[k]);
    end

    wait_cyc(10 + 40 * 8 + 24);
    check("pre_async_com", fnd_com, 4'b1011);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_com", fnd_com, 4'hF);
    check("async_rst_font", fnd_font, 8'hFF);
    sb.delete();
    prev_com   = 4'hF;
    prev_font  = 8'hFF;
    hold       = 0;
    font_moved = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_com", fnd_com, 4'hF);

    drive(mk(0, 0, 0, 0, 0));
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_cyc(10);
    check("restart_pre_com", fnd_com, 4'hF);
    wait_cyc(11);
    check("restart_com", fnd_com, 4'b1110);

    for (int i = 1; i < 100; i++) begin
      wait_cyc(10 + 40 * i - 25);
      drive(mk((i % 4) == 3, i, (i * 7) % 60, (i * 11) % 60, i % 24));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
